// File: rtl/wb_arb_pkg.sv
// Shared constants for the writeback port arbiter: register-file geometry,
// requester indices and a one-hot decode helper.
package wb_arb_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    localparam int unsigned WB_SRC_ALU    = 0;
    localparam int unsigned WB_SRC_LOAD   = 1;
    localparam int unsigned WB_SRC_MULDIV = 2;
    localparam int unsigned WB_NUM_SRC    = 3;

    // Index of the set bit in a one-hot (or zero) vector of up to 8 requesters.
    function automatic int unsigned onehot_idx(input logic [7:0] v);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/wb_arb_picker.sv
// Combinational one-hot picker. Round-robin from a start pointer when
// WB_ARB_RR_EN is defined, lowest-index-wins priority encoder otherwise.
module wb_arb_picker #(
    parameter int unsigned NUM_REQ = 3
) (
    input  logic [NUM_REQ-1:0]         valid,
`ifdef WB_ARB_RR_EN
    input  logic [$clog2(NUM_REQ)-1:0] start,
`endif
    output logic [NUM_REQ-1:0]         grant
);

`ifdef WB_ARB_RR_EN
    // Walk the requesters starting at the pointer, wrapping modulo NUM_REQ;
    // the first valid one found wins.
    always_comb begin
        int unsigned idx;
        idx   = 0;
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = 32'(start) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if ((grant == '0) && valid[idx]) begin
                grant[idx] = 1'b1;
            end
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if ((grant == '0) && valid[i]) begin
                grant[i] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: grants one source per cycle into a one-entry write
// stage that drives the register file. WB_ARB_RR_EN selects round-robin.
module wb_port_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = WB_NUM_SRC,
    parameter int unsigned ADDR_W  = REG_ADDR_W,
    parameter int unsigned DATA_W  = REG_DATA_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wb_arb_flush_i,
    input  logic [NUM_REQ-1:0]        wb_arb_req_valid_i,
    input  logic [NUM_REQ*ADDR_W-1:0] wb_arb_req_waddr_i,
    input  logic [NUM_REQ*DATA_W-1:0] wb_arb_req_wdata_i,
    output logic [NUM_REQ-1:0]        wb_arb_req_ready_o,
    output logic                      wb_arb_rf_we_o,
    output logic [ADDR_W-1:0]         wb_arb_rf_waddr_o,
    output logic [DATA_W-1:0]         wb_arb_rf_wdata_o,
    output logic                      wb_arb_busy_o
);

    logic [NUM_REQ-1:0] grant;
    logic [NUM_REQ-1:0] ready;
    logic               accept;
    logic [ADDR_W-1:0]  sel_addr;
    logic [DATA_W-1:0]  sel_data;

`ifdef WB_ARB_RR_EN
    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] rr_ptr_next;

    wb_arb_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (wb_arb_req_valid_i),
        .start (rr_ptr),
        .grant (grant)
    );

    always_comb begin
        int unsigned idx;
        idx = onehot_idx(8'(ready));
        if (idx + 1 >= NUM_REQ) begin
            rr_ptr_next = '0;
        end else begin
            rr_ptr_next = PTR_W'(idx + 1);
        end
    end

    // Pointer only advances on a real transfer; flush suppresses ready, so it holds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= rr_ptr_next;
        end
    end
`else
    wb_arb_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
        .valid (wb_arb_req_valid_i),
        .grant (grant)
    );
`endif

    assign ready  = (rst || wb_arb_flush_i) ? '0 : grant;
    assign accept = |ready;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (ready[k]) begin
                sel_addr = wb_arb_req_waddr_i[k*ADDR_W +: ADDR_W];
                sel_data = wb_arb_req_wdata_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // Register 0 writes are consumed but never raise the write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_arb_rf_we_o    <= 1'b0;
            wb_arb_rf_waddr_o <= '0;
            wb_arb_rf_wdata_o <= '0;
        end else if (accept) begin
            wb_arb_rf_we_o    <= (sel_addr != ADDR_W'(ZERO_REG));
            wb_arb_rf_waddr_o <= sel_addr;
            wb_arb_rf_wdata_o <= sel_data;
        end else begin
            wb_arb_rf_we_o    <= 1'b0;
        end
    end

    assign wb_arb_req_ready_o = ready;
    assign wb_arb_busy_o      = (|(wb_arb_req_valid_i & ~ready)) & ~rst;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: per-cycle model comparison plus
// hand-computed expectations; follows WB_ARB_RR_EN like the design.
module tb_wb_port_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic [N-1:0]   valid = '0;
    logic [N*AW-1:0] waddr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]   ready;
    logic           we;
    logic [AW-1:0]  rf_addr;
    logic [DW-1:0]  rf_data;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    wb_port_arbiter #(
        .NUM_REQ (N),
        .ADDR_W  (AW),
        .DATA_W  (DW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .wb_arb_flush_i     (flush),
        .wb_arb_req_valid_i (valid),
        .wb_arb_req_waddr_i (waddr),
        .wb_arb_req_wdata_i (wdata),
        .wb_arb_req_ready_o (ready),
        .wb_arb_rf_we_o     (we),
        .wb_arb_rf_waddr_o  (rf_addr),
        .wb_arb_rf_wdata_o  (rf_data),
        .wb_arb_busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model state: what the write stage and arbitration pointer must hold.
    int          m_ptr  = 0;
    bit          m_we   = 1'b0;
    int unsigned m_addr = 0;
    int unsigned m_data = 0;

    function automatic int model_winner(input logic [N-1:0] v, input int ptr);
        for (int i = 0; i < N; i++) begin
`ifdef WB_ARB_RR_EN
            int k = (ptr + i) % N;
`else
            int k = i;
`endif
            if (v[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] model_ready();
        int w;
        if (rst || flush) return '0;
        w = model_winner(valid, m_ptr);
        if (w < 0) return '0;
        return N'(1) << w;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr  = 0;
            m_we   = 1'b0;
            m_addr = 0;
            m_data = 0;
        end else begin
            int w;
            w = (flush) ? -1 : model_winner(valid, m_ptr);
            if (w >= 0) begin
                m_addr = (waddr >> (w * AW)) & ((1 << AW) - 1);
                m_data = 32'(wdata >> (w * DW));
                m_we   = (m_addr != 0);
                m_ptr  = (w + 1) % N;
            end else begin
                m_we = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        er = model_ready();
        chk("cyc_ready", 64'(ready), 64'(er));
        chk("cyc_busy", 64'(busy), 64'((|(valid & ~er)) && !rst));
        chk("cyc_we", 64'(we), 64'(m_we));
        chk("cyc_waddr", 64'(rf_addr), 64'(m_addr));
        chk("cyc_wdata", 64'(rf_data), 64'(m_data));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        waddr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = d;
    endtask

    // Advance one edge and retract every requester that was just accepted.
    task automatic step_drop();
        logic [N-1:0] r;
        r = ready;
        step();
        valid = valid & ~r;
        #1;
    endtask

    logic [N-1:0] tbl_valid [8] = '{3'b101, 3'b011, 3'b111, 3'b000, 3'b110, 3'b111, 3'b100, 3'b011};
    logic         tbl_flush [8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        logic [N-1:0] rr_hold [3];
`ifdef WB_ARB_RR_EN
        rr_hold = '{3'b010, 3'b100, 3'b010};
`else
        rr_hold = '{3'b010, 3'b010, 3'b010};
`endif
        step();
        step();
        chk("reset_we", 64'(we), 64'd0);
        chk("reset_waddr", 64'(rf_addr), 64'd0);
        chk("reset_ready", 64'(ready), 64'd0);
        rst = 1'b0;
        step();

        set_req(1, 5'd7, 32'hDEADBEEF);
        valid = 3'b010;
        #1;
        chk("single_ready", 64'(ready), 64'b010);
        chk("single_busy", 64'(busy), 64'd0);
        step();
        valid = '0;
        chk("single_we", 64'(we), 64'd1);
        chk("single_waddr", 64'(rf_addr), 64'd7);
        chk("single_wdata", 64'(rf_data), 64'hDEADBEEF);
        step();
        chk("single_we_drop", 64'(we), 64'd0);
        chk("single_addr_hold", 64'(rf_addr), 64'd7);

        set_req(1, 5'd9, 32'h12345678);
        valid = 3'b010;
        step();
        valid = 3'b111;
        chk("midrst_we_before", 64'(we), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_we", 64'(we), 64'd0);
        chk("midrst_waddr", 64'(rf_addr), 64'd0);
        chk("midrst_wdata", 64'(rf_data), 64'd0);
        chk("midrst_ready", 64'(ready), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        valid = '0;
        step();
        rst = 1'b0;
        step();

        set_req(0, 5'd1, 32'hA);
        set_req(1, 5'd2, 32'hB);
        set_req(2, 5'd3, 32'hC);
        valid = 3'b111;
        #1;
        chk("cont_g0", 64'(ready), 64'b001);
        chk("cont_b0", 64'(busy), 64'd1);
        step_drop();
        chk("cont_g1", 64'(ready), 64'b010);
        chk("cont_b1", 64'(busy), 64'd1);
        chk("cont_w0", 64'(rf_data), 64'hA);
        step_drop();
        chk("cont_g2", 64'(ready), 64'b100);
        chk("cont_b2", 64'(busy), 64'd0);
        chk("cont_w1", 64'(rf_data), 64'hB);
        step_drop();
        chk("cont_w2", 64'(rf_data), 64'hC);
        chk("cont_a2", 64'(rf_addr), 64'd3);

        valid = 3'b110;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold110_grant", 64'(ready), 64'(rr_hold[i]));
            chk("hold110_busy", 64'(busy), 64'd1);
            step();
        end
        valid = 3'b100;
        #1;
        chk("drop1_grant", 64'(ready), 64'b100);
        chk("drop1_busy", 64'(busy), 64'd0);
        step();
        valid = '0;
        step();

        set_req(0, 5'd0, 32'h1);
        valid = 3'b001;
        #1;
        chk("r0_ready", 64'(ready), 64'b001);
        step();
        valid = '0;
        chk("r0_we", 64'(we), 64'd0);
        chk("r0_wdata", 64'(rf_data), 64'd1);

        flush = 1'b1;
        valid = 3'b100;
        #1;
        chk("flush_ready", 64'(ready), 64'd0);
        chk("flush_busy", 64'(busy), 64'd1);
        step();
        chk("flush_we", 64'(we), 64'd0);
        flush = 1'b0;
        valid = 3'b111;
        #1;
`ifdef WB_ARB_RR_EN
        chk("flush_ptr_hold", 64'(ready), 64'b010);
`else
        chk("flush_ptr_hold", 64'(ready), 64'b001);
`endif
        valid = 3'b001;
        set_req(0, 5'd4, 32'h5);
        step();
        valid = '0;
        chk("full_we", 64'(we), 64'd1);
        chk("full_waddr", 64'(rf_addr), 64'd4);
        flush = 1'b1;
        step();
        chk("full_flush_we", 64'(we), 64'd0);
        flush = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_req(0, AW'(i + 10), 32'(32'h100 + i));
            set_req(1, AW'(i + 20), 32'(32'h200 + i));
            set_req(2, AW'(i), 32'(32'h300 + i));
            valid = tbl_valid[i];
            flush = tbl_flush[i];
            step();
        end
        valid = '0;
        flush = 1'b0;
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
